maze_path_rle: RTL and testbench
================================

Name: maze_path_rle

Overview:
- Downstream stage of the maze solver. Consumes the solver's serial direction stream (one 2-bit direction per cycle while the solver's out_valid is high).
- Tracks position from (0,0) and run-length encodes the path into (dir, len) tokens.
- Buffers tokens in a small FIFO behind a valid/ready handshake.
- Reports step count and whether the path legally ends at (MAZE_WIDTH-1, MAZE_WIDTH-1).

Parameters:
DIR_WIDTH, 2, direction width; encoding RIGHT=0, DOWN=1, LEFT=2, UP=3
MAZE_WIDTH, 17, maze side length; goal is (MAZE_WIDTH-1, MAZE_WIDTH-1)
POS_WIDTH, 6, signed x/y tracker width
CNT_WIDTH, 5, token run-length width; max run RUN_MAX = 2^CNT_WIDTH-1
FIFO_DEPTH, 8, token FIFO entries
STEP_WIDTH, 9, step counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  direction valid; solver's out_valid, high for one contiguous burst per path
in_dir  in  DIR_WIDTH  direction; solver's out
tok_valid  out  1  token available at FIFO head
tok_ready  in  1  consumer accepts head token when tok_valid & tok_ready
tok_dir  out  DIR_WIDTH  token direction
tok_len  out  CNT_WIDTH  token run length, 1..RUN_MAX
tok_last  out  1  final token of the path
done  out  1  one-cycle pulse when the path is fully drained
path_ok  out  1  path verdict, valid from done until the next path starts
step_cnt  out  STEP_WIDTH  total directions received
err  out  1  sticky protocol/overflow error for the current path

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all outputs 0; FIFO emptied; state IDLE; x=y=0; run state cleared. Reset mid-path abandons the path; no tokens survive. No upstream stall exists: in_valid is never back-pressured.
- Position update per accepted direction:
  - RIGHT: y+1
  - DOWN: x+1
  - LEFT: y-1
  - UP: x-1
  - Signed POS_WIDTH arithmetic.
  - oob flag (internal, sticky) sets if the new x or y is <0 or >MAZE_WIDTH-1.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE, when in_valid=1:
  - Latch cur_dir=in_dir, run_len=1, step_cnt=1.
  - Clear err, oob, path_ok. Set x/y to the first step from (0,0).
  - Go RUN.
- RUN, in_valid=1:
  - step_cnt += 1, saturating at 2^STEP_WIDTH-1.
  - If in_dir==cur_dir and run_len<RUN_MAX: run_len += 1.
  - Otherwise: push token (cur_dir, run_len, last=0), then cur_dir=in_dir, run_len=1.
- RUN, in_valid=0: the burst has ended. Push (cur_dir, run_len, last=1) and go FLUSH.
- FLUSH: wait until the FIFO is empty and no pop is pending, then go DONE.
- DONE (one cycle):
  - done=1.
  - path_ok = (x==MAZE_WIDTH-1) & (y==MAZE_WIDTH-1) & !oob & !err.
  - Go IDLE. step_cnt, path_ok and err hold until the next path's first in_valid.
- in_valid=1 in FLUSH or DONE: direction ignored, err=1.
- FIFO:
  - First-word fall-through. A pushed token appears on tok_valid the cycle after the push edge.
  - Pop on tok_valid & tok_ready.
  - Push when full and no same-cycle pop: token dropped, err=1.
  - Push when full with a same-cycle pop: accepted, count unchanged.
  - Push when empty with tok_ready=1: the token is still presented for at least one cycle (no bypass).
- tok_* outputs are stable while tok_valid=1 and tok_ready=0.
- The last=1 token is pushed even when that push overflows; if dropped, err=1 and FLUSH still completes.

Test Plan:
1. Stream R,R,R,D,D, then in_valid=0, tok_ready=1.
   -> Tokens (0,3,0), (1,2,1); step_cnt=5; done pulses once; path_ok=0 (end pos (2,3)).
2. 16×RIGHT then 16×DOWN, tok_ready=1.
   -> Tokens (0,16,0), (1,16,1); step_cnt=32; done pulse; path_ok=1; err=0.
3. 33×RIGHT.
   -> Tokens (0,31,0), (0,2,1); oob set at the 17th step; path_ok=0; step_cnt=33.
4. tok_ready=0, alternating R,D for 10 steps.
   -> 8 tokens buffered, 9th and 10th dropped, err=1.
   -> Then tok_ready=1: exactly 8 tokens drain, done pulses, path_ok=0.
5. FIFO holding 8 entries, tok_ready=1 in the same cycle a run closes.
   -> Push accepted, no err, tok_valid stays high, ordering preserved.
6. rst=1 for one cycle after 5 directions of a path.
   -> tok_valid=0, step_cnt=0, err=0, done never pulses.
   -> A new path afterwards encodes from (0,0) correctly.

Source files
------------

// File: rtl/maze_path_rle.sv
// Downstream stage of the maze solver: tracks position, run-length encodes the
// direction stream into (dir, len, last) tokens and buffers them in a FWFT FIFO.
module maze_path_rle #(
  parameter int unsigned DIR_WIDTH  = 2,
  parameter int unsigned MAZE_WIDTH = 17,
  parameter int unsigned POS_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH  = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STEP_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DIR_WIDTH-1:0]  in_dir,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic [DIR_WIDTH-1:0]  tok_dir,
  output logic [CNT_WIDTH-1:0]  tok_len,
  output logic                  tok_last,
  output logic                  done,
  output logic                  path_ok,
  output logic [STEP_WIDTH-1:0] step_cnt,
  output logic                  err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = DIR_WIDTH + CNT_WIDTH + 1;
  localparam logic signed [POS_WIDTH-1:0] GOAL = POS_WIDTH'(MAZE_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                       r_state, w_next;
  logic [DIR_WIDTH-1:0]         r_cur_dir;
  logic [CNT_WIDTH-1:0]         r_run_len;
  logic [STEP_WIDTH-1:0]        r_step;
  logic signed [POS_WIDTH-1:0]  r_x, r_y, w_bx, w_by, w_nx, w_ny;
  logic                         r_oob, w_oob_new, r_err, r_path_ok;

  logic [ENT_W-1:0]             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             r_rd, r_wr;
  logic [PTR_W:0]               r_count;
  logic                         w_valid, w_pop, w_full;
  logic                         w_push_req, w_push_ok, w_drop, w_err_set, w_close;
  logic [ENT_W-1:0]             w_push_data, w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The first step of a path is taken from the origin, not the previous path's end
  always_comb begin
    w_bx = (r_state == S_IDLE) ? '0 : r_x;
    w_by = (r_state == S_IDLE) ? '0 : r_y;
    w_nx = w_bx;
    w_ny = w_by;
    case (in_dir)
      DIR_WIDTH'(0): w_ny = w_by + POS_WIDTH'(1);
      DIR_WIDTH'(1): w_nx = w_bx + POS_WIDTH'(1);
      DIR_WIDTH'(2): w_ny = w_by - POS_WIDTH'(1);
      DIR_WIDTH'(3): w_nx = w_bx - POS_WIDTH'(1);
      default: ;
    endcase
    w_oob_new = w_nx[POS_WIDTH-1] | w_ny[POS_WIDTH-1] | (w_nx > GOAL) | (w_ny > GOAL);
  end

  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & tok_ready;
  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_close   = (in_dir != r_cur_dir) | (r_run_len == '1);
  assign w_push_ok = w_push_req & (~w_full | w_pop);
  assign w_drop    = w_push_req & w_full & ~w_pop;
  assign w_err_set = w_drop | (in_valid & ((r_state == S_FLUSH) | (r_state == S_DONE)));

  always_comb begin
    w_next      = r_state;
    w_push_req  = 1'b0;
    w_push_data = '0;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_RUN;
      S_RUN: begin
        if (in_valid) begin
          if (w_close) begin
            w_push_req  = 1'b1;
            w_push_data = {1'b0, r_run_len, r_cur_dir};
          end
        end else begin
          w_push_req  = 1'b1;
          w_push_data = {1'b1, r_run_len, r_cur_dir};
          w_next      = S_FLUSH;
        end
      end
      S_FLUSH: if ((r_count == '0) && !w_pop) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cur_dir <= '0;
      r_run_len <= '0;
      r_step    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_oob     <= 1'b0;
      r_err     <= 1'b0;
      r_path_ok <= 1'b0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_cur_dir <= in_dir;
          r_run_len <= CNT_WIDTH'(1);
          r_step    <= STEP_WIDTH'(1);
          r_err     <= 1'b0;
          r_oob     <= w_oob_new;
          r_path_ok <= 1'b0;
          r_x       <= w_nx;
          r_y       <= w_ny;
        end
        S_RUN: if (in_valid) begin
          r_step <= (r_step == '1) ? r_step : r_step + STEP_WIDTH'(1);
          r_x    <= w_nx;
          r_y    <= w_ny;
          r_oob  <= r_oob | w_oob_new;
          if (w_close) begin
            r_cur_dir <= in_dir;
            r_run_len <= CNT_WIDTH'(1);
          end else begin
            r_run_len <= r_run_len + CNT_WIDTH'(1);
          end
        end
        // Verdict is latched on entry to DONE so it is valid alongside the done pulse
        S_FLUSH: if (w_next == S_DONE)
          r_path_ok <= (r_x == GOAL) & (r_y == GOAL) & ~r_oob & ~(r_err | w_err_set);
        default: ;
      endcase
      if (w_err_set) r_err <= 1'b1;

      if (w_push_ok) begin
        r_mem[r_wr] <= w_push_data;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd];
  assign tok_valid = w_valid;
  assign tok_dir   = w_valid ? w_head[DIR_WIDTH-1:0] : '0;
  assign tok_len   = w_valid ? w_head[DIR_WIDTH +: CNT_WIDTH] : '0;
  assign tok_last  = w_valid ? w_head[ENT_W-1] : 1'b0;
  assign done      = (r_state == S_DONE);
  assign path_ok   = r_path_ok;
  assign step_cnt  = r_step;
  assign err       = r_err;

endmodule

// File: tb/tb_maze_path_rle.sv
// Bench for maze_path_rle: directed and random paths checked against a
// list-based run-length/position model of the path.
module tb_maze_path_rle;

  logic       clk = 1'b0;
  logic       rst, in_valid, tok_ready;
  logic [1:0] in_dir;
  logic       tok_valid, tok_last, done, path_ok, err;
  logic [1:0] tok_dir;
  logic [4:0] tok_len;
  logic [8:0] step_cnt;

  maze_path_rle #(
    .DIR_WIDTH(2), .MAZE_WIDTH(17), .POS_WIDTH(6),
    .CNT_WIDTH(5), .FIFO_DEPTH(8), .STEP_WIDTH(9)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dir(in_dir),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_dir(tok_dir),
    .tok_len(tok_len), .tok_last(tok_last), .done(done), .path_ok(path_ok),
    .step_cnt(step_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int got_q[$];
  int exp_q[$];
  int path_q[$];
  int done_cnt = 0;
  int stab_bad = 0;
  int exp_step;
  bit exp_ok, exp_err;
  bit prev_hold = 1'b0;
  int prev_tok  = 0;

  function automatic int pack(input int last, input int len, input int dir);
    return last * 65536 + len * 256 + dir;
  endfunction

  // Mid-cycle monitor: records accepted tokens, done pulses and head stability
  always @(negedge clk) begin
    int cur;
    cur = pack(int'(tok_last), int'(tok_len), int'(tok_dir));
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !(tok_valid === 1'b1 && cur == prev_tok)) stab_bad++;
      if (done === 1'b1) done_cnt++;
      if (tok_valid === 1'b1 && tok_ready) got_q.push_back(cur);
      prev_hold = (tok_valid === 1'b1) && !tok_ready;
      prev_tok  = cur;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] d, input logic r);
    in_valid  = v;
    in_dir    = d;
    tok_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Reference: RLE of the direction list with a 31-step cap, walk from origin
  task automatic build_expect(input int mode);
    int cur, len, x, y, n;
    bit oob;
    exp_q.delete();
    n = path_q.size();
    cur = path_q[0]; len = 1; x = 0; y = 0; oob = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (path_q[i])
        0: y++;
        1: x++;
        2: y--;
        default: x--;
      endcase
      if (x < 0 || y < 0 || x > 16 || y > 16) oob = 1'b1;
      if (i > 0) begin
        if (path_q[i] == cur && len < 31) len++;
        else begin
          exp_q.push_back(pack(0, len, cur));
          cur = path_q[i];
          len = 1;
        end
      end
    end
    exp_q.push_back(pack(1, len, cur));
    exp_err = 1'b0;
    if (mode == 0 && exp_q.size() > 8) begin
      exp_err = 1'b1;
      while (exp_q.size() > 8) void'(exp_q.pop_back());
    end
    exp_step = (n > 511) ? 511 : n;
    exp_ok   = (x == 16) && (y == 16) && !oob && !exp_err;
  endtask

  // mode 0: ready low through burst; 1: ready high; 2: random ready;
  // 3: ready low except on the final direction
  task automatic run_path(input string tag, input int mode);
    int d0, n;
    logic r;
    got_q.delete();
    d0 = done_cnt;
    n  = path_q.size();
    build_expect(mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = ($urandom_range(0, 3) != 0);
        default: r = (i == n - 1);
      endcase
      cyc(1'b1, 2'(path_q[i]), r);
    end
    if (mode == 3) begin
      chk({tag, "_hold_valid"}, 32'(tok_valid), 32'd1);
      chk({tag, "_hold_err"}, 32'(err), 32'd0);
    end
    case (mode)
      0:       r = 1'b0;
      2:       r = ($urandom_range(0, 3) != 0);
      default: r = 1'b1;
    endcase
    cyc(1'b0, 2'd0, r);
    for (int t = 0; t < 300; t++) begin
      if (done_cnt != d0) break;
      cyc(1'b0, 2'd0, (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b1);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_step"}, 32'(step_cnt), 32'(exp_step));
    chk({tag, "_path_ok"}, 32'(path_ok), 32'(exp_ok));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_empty"}, 32'(tok_valid), 32'd0);
    chk({tag, "_ntok"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_tok%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic add_run(input int d, input int len);
    for (int i = 0; i < len; i++) path_q.push_back(d);
  endtask

  initial begin
    int k, prev, d;
    rst = 1'b1; in_valid = 1'b0; in_dir = 2'd0; tok_ready = 1'b0;
    cyc(1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    chk("rst_tok_valid", 32'(tok_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_path_ok", 32'(path_ok), 32'd0);
    chk("rst_step", 32'(step_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tok_fields", 32'({tok_last, tok_len, tok_dir}), 32'd0);

    path_q.delete(); add_run(0, 3); add_run(1, 2);
    run_path("t1", 1);

    path_q.delete(); add_run(0, 16); add_run(1, 16);
    run_path("t2", 1);

    path_q.delete(); add_run(0, 33);
    run_path("t3", 1);

    path_q.delete();
    for (int i = 0; i < 10; i++) path_q.push_back(i % 2);
    run_path("t4", 0);

    path_q.delete();
    for (int i = 0; i < 10; i++) path_q.push_back(i % 2);
    run_path("t5", 3);

    // Reset mid-path with tokens buffered
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'(i % 2), 1'b0);
    rst = 1'b1;
    cyc(1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    chk("t6_tok_valid", 32'(tok_valid), 32'd0);
    chk("t6_step", 32'(step_cnt), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    k = done_cnt;
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'd0, 1'b1);
    chk("t6_no_done", 32'(done_cnt - k), 32'd0);
    path_q.delete(); add_run(0, 3); add_run(1, 2);
    run_path("t6_after", 1);

    path_q.delete(); add_run(2, 1); add_run(1, 4);
    run_path("left_oob", 1);

    for (int p = 0; p < 8; p++) begin
      path_q.delete();
      k = $urandom_range(1, 8);
      prev = -1;
      for (int j = 0; j < k; j++) begin
        do d = $urandom_range(0, 3); while (d == prev);
        add_run(d, $urandom_range(1, 12));
        prev = d;
      end
      run_path($sformatf("rnd%0d", p), (p % 3 == 0) ? 1 : 2);
    end

    chk("tok_stable", 32'(stab_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
